// File: rtl/fir_norm_pkg.sv
// Shared widths and rounding constants for the fir_norm filter.
// Optional saturation is selected with FIR_NORM_SAT_EN (see fir_norm_round_sat).
package fir_norm_pkg;

  localparam int DATA_W     = 16;
  localparam int COEF_W     = 16;
  localparam int FRAC_W     = 15;
  localparam int PROD_W     = DATA_W + COEF_W;
  localparam int ROUND_HALF = 1 << (FRAC_W - 1);

  // Headroom for TAPS full-scale products so the sum can never overflow.
  function automatic int acc_w(input int taps);
    return PROD_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_norm_round_sat.sv
// Round-half-up and divide by 2^15, then reduce to 16 bits.
// FIR_NORM_SAT_EN defined: clamp to the Q1.15 range; undefined: two's-complement wrap.
module fir_norm_round_sat
  import fir_norm_pkg::*;
#(
  parameter int ACC_W = 38
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] r_o
);

  logic [ACC_W:0]        sum;
  logic [ACC_W-FRAC_W:0] sh;
  logic                  unused_ok;

  // One extra bit so adding the rounding constant cannot overflow.
  assign sum = {acc_i[ACC_W-1], acc_i} + (ACC_W+1)'(ROUND_HALF);
  assign sh  = sum[ACC_W:FRAC_W];

`ifdef FIR_NORM_SAT_EN
  logic in_range;

  // Result fits when every bit above the 16-bit field matches its sign bit.
  assign in_range  = (&sh[ACC_W-FRAC_W:DATA_W-1]) | ~(|sh[ACC_W-FRAC_W:DATA_W-1]);
  assign unused_ok = ^sum[FRAC_W-1:0];

  always_comb begin
    r_o = sh[DATA_W-1:0];
    if (!in_range)
      r_o = sh[ACC_W-FRAC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign unused_ok = ^{sh[ACC_W-FRAC_W:DATA_W], sum[FRAC_W-1:0]};
  assign r_o       = sh[DATA_W-1:0];
`endif

endmodule

// File: rtl/fir_norm.sv
// Direct-form fully parallel FIR: TAPS-deep delay line, full-precision product sum,
// rounded/normalised registered output. FIR_NORM_SAT_EN enables output saturation.
module fir_norm
  import fir_norm_pkg::*;
#(
  parameter int TAPS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TAPS*COEF_W-1:0] coefs_i,
  input  logic [DATA_W-1:0]      in_i,
  output logic [DATA_W-1:0]      out_o
);

  localparam int ACC_W = acc_w(TAPS);

  logic [TAPS-1:0][DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0]           out_q, out_d;
  logic signed [PROD_W-1:0]    prod [TAPS];
  logic signed [ACC_W-1:0]     acc;

  always_comb begin
    x_d    = x_q;
    x_d[0] = in_i;
    for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
  end

  for (genvar k = 0; k < TAPS; k++) begin : gen_tap
    assign prod[k] = $signed(coefs_i[k*COEF_W +: COEF_W]) * $signed(x_q[k]);
  end

  // Single combinational adder path; pipelining here would shift the output latency.
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod[k]);
  end

  fir_norm_round_sat #(.ACC_W(ACC_W)) u_round_sat (
    .acc_i (acc),
    .r_o   (out_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      out_q <= '0;
    end else begin
      x_q   <= x_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: tb/tb_fir_norm.sv
// Self-checking bench for fir_norm: impulse vector table, reset sequences, and a
// reference-model scoreboard for DC gain, saturation/wrap and random traffic.
module tb_fir_norm;

  localparam int TAPS = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [TAPS*16-1:0]   coefs;
  logic [15:0]          din = '0;
  logic [15:0]          dout;

  logic signed [15:0]   cf [TAPS];
  logic signed [15:0]   mx [TAPS];
  logic signed [15:0]   exp_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    coefs = '0;
    for (int k = 0; k < TAPS; k++) coefs[16*k +: 16] = cf[k];
  end

  fir_norm #(.TAPS(TAPS)) dut (
    .clk     (clk),
    .rst     (rst),
    .coefs_i (coefs),
    .in_i    (din),
    .out_o   (dout)
  );

  // Reference: exact sum, floor((acc + 2^14) / 2^15), then clamp or wrap.
  function automatic logic signed [15:0] model_out();
    longint acc = 0;
    longint r;
    for (int k = 0; k < TAPS; k++) acc += longint'(cf[k]) * longint'(mx[k]);
    r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_NORM_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic check(input string name, input logic signed [15:0] exp);
    checks++;
    if ($signed(dout) !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(dout), exp);
    end
  endtask

  // Drive one sample, predict the output registered on this edge, compare after it.
  task automatic step(input logic signed [15:0] s, input string name);
    logic signed [15:0] e;
    din = s;
    exp_q.push_back(model_out());
    for (int k = TAPS-1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, e);
  endtask

  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) mx[k] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic signed [15:0] din;
    logic signed [15:0] exp;
  } vec_t;

  initial begin
    vec_t imp [7];
    for (int k = 0; k < TAPS; k++) cf[k] = '0;
    clear_model();

    // Reset: output held at zero asynchronously, before and across edges.
    din = 16'sd12345;
    #3;
    check("reset_initial", 16'sd0);
    cf[0] = 16'sd16384;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 16'sd0);

    // Release: first edge sees empty history, second shows 12345/2 rounded up.
    rst = 1'b0;
    step(16'sd12345, "release_edge1");
    check("release_edge1_zero", 16'sd0);
    step(16'sd12345, "release_edge2");
    check("release_edge2_val", 16'sd6173);

    // Mid-stream reset: immediate clear, and history is gone afterwards.
    for (int i = 0; i < 5; i++) step(16'sd20000, "pre_midreset");
    #2;
    rst = 1'b1;
    #1;
    check("midreset_async", 16'sd0);
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(16'sd0, "after_midreset");
    check("after_midreset_zero", 16'sd0);

    // Impulse: c[0]=0.5, c[3]=-0.25. floor(-8191.75 + 0.5) = -8192.
    imp[0] = '{16'sd32767, 16'sd0};
    imp[1] = '{16'sd0,     16'sd16384};
    imp[2] = '{16'sd0,     16'sd0};
    imp[3] = '{16'sd0,     16'sd0};
    imp[4] = '{16'sd0,    -16'sd8192};
    imp[5] = '{16'sd0,     16'sd0};
    imp[6] = '{16'sd0,     16'sd0};
    cf[0] = 16'sd16384;
    cf[3] = -16'sd8192;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(imp[i].din, "impulse_model");
      check($sformatf("impulse_tbl%0d", i), imp[i].exp);
    end

    // DC gain: 64 x 512 = unity; ramp in ~15.625 steps, then exactly 1000.
    for (int k = 0; k < TAPS; k++) cf[k] = 16'sd512;
    do_reset();
    for (int i = 1; i <= 70; i++) begin
      step(16'sd1000, "dc_model");
      if (i == 2) check("dc_first_step", 16'sd16);
      if (i == 3) check("dc_second_step", 16'sd31);
      if (i >= 65) check("dc_settled", 16'sd1000);
    end

    // Full-scale positive and negative: clamps, or low 16 bits of r when wrapping.
    for (int k = 0; k < TAPS; k++) cf[k] = 16'sd32767;
    do_reset();
    for (int i = 0; i < 66; i++) step(16'sd32767, "sat_pos_model");
`ifdef FIR_NORM_SAT_EN
    check("sat_pos", 16'sd32767);
`else
    check("wrap_pos", -16'sd128);
`endif
    for (int i = 0; i < 66; i++) step(-16'sd32768, "sat_neg_model");
`ifdef FIR_NORM_SAT_EN
    check("sat_neg", -16'sd32768);
`else
    check("wrap_neg", 16'sd64);
`endif

    // Random coefficients and samples, with a coefficient change mid-stream.
    for (int k = 0; k < TAPS; k++) cf[k] = 16'($urandom_range(0, 65535)) >>> 3;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      if (i == 90) cf[5] = -16'sd20000;
      step(16'($urandom_range(0, 65535)), "random_model");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
